banner_renderer: RTL and testbench
==================================

# banner_renderer

Pixel-pipeline stage that consumes the 224×32 "PLAYER 1" banner font ROM and turns it into video. It sits between the VGA sync generator and the colour multiplexer. It maps the current pixel coordinate to a ROM row address, selects the addressed bitmap column from the returned 224-bit row, and emits a registered 12-bit colour two cycles later. A frame-synchronous visibility FSM shows, hides or blinks the banner when a player wins.

## Interface
Parameters:
- X0, 208: left column of banner on screen.
- Y0, 100: top row of banner on screen.
- BLINK_FRAMES, 30: frames per blink half-period (≥1).
- BLINK_COUNT, 3: number of on/off blink pairs (≥1).
- FG_COLOR, 12'hFFF: colour of set bitmap pixels.

Ports:
- clk  in  1  pixel clock (one pixel per cycle).
- reset  in  1  asynchronous, active-high; clears all state.
- pixel_x  in  10  current column from sync generator.
- pixel_y  in  10  current row from sync generator.
- video_on  in  1  active-video flag, aligned with pixel_x/pixel_y.
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blank.
- show  in  1  level; banner requested.
- win  in  1  one-cycle pulse; start blink sequence.
- rom_addr  out  5  row address to font ROM.
- rom_data  in  224  row bits from the combinational font ROM, declared [0:223]; element 0 is the leftmost pixel.
- rgb  out  12  pixel colour.
- pixel_on  out  1  banner pixel lit.
- busy  out  1  high in either blink state.
- blink_done  out  1  one-cycle pulse when the blink sequence ends.

## Operation
- Stage 1 (registered):
  - hit = video_on & X0≤pixel_x≤X0+223 & Y0≤pixel_y≤Y0+31.
  - col_q = pixel_x−X0, 8 bits.
  - rom_addr = hit ? (pixel_y−Y0)[4:0] : 0.
  - Also register hit_q and von_q.
  - Comparisons use 11-bit unsigned arithmetic, so there is no wrap when X0+223 exceeds 1023.
- ROM lookup: combinational, driven from rom_addr. It resolves within the stage-2 cycle.
- Stage 2 (registered):
  - bit = rom_data[col_q].
  - pixel_on = hit_q & visible & bit.
  - rgb = pixel_on ? FG_COLOR : 12'h000, forced to 0 when von_q=0.
- visible = state∈{ON, BLINK_ON}.
- FSM states: OFF, ON, BLINK_ON, BLINK_OFF.
  - show=0 in any state → OFF. Counters are cleared, and show=0 takes priority over win.
  - OFF: show=1 → ON.
  - ON: win=1 → BLINK_ON, with frame_cnt=0 and pair_cnt=0.
  - BLINK_ON: on frame_tick, if frame_cnt==BLINK_FRAMES−1 → BLINK_OFF with frame_cnt=0; else frame_cnt+1.
  - BLINK_OFF: on frame_tick, if frame_cnt==BLINK_FRAMES−1:
    - if pair_cnt==BLINK_COUNT−1 → ON and pulse blink_done;
    - else → BLINK_ON with pair_cnt+1 and frame_cnt=0.
    - Otherwise frame_cnt+1.
  - win in BLINK_ON/BLINK_OFF is ignored (no restart).
  - win coincident with frame_tick in ON: win is taken, and that tick is not counted.
- Counter widths: $clog2(BLINK_FRAMES+1) and $clog2(BLINK_COUNT+1).
- Reset values: rgb=0, pixel_on=0, rom_addr=0, busy=0, blink_done=0, state=OFF, all pipeline flags 0.

## Timing
- Latency: pixel_x/pixel_y/video_on at edge N → rgb/pixel_on valid after edge N+2. Downstream delays hsync/vsync by 2.
- rom_addr is valid 1 cycle after the coordinate. The ROM path must close in one clock.
- FSM transitions on the same edge that samples frame_tick/win/show. visible affects the stage-2 register on the next edge.
- busy is registered: high the cycle after entering BLINK_ON, low the cycle after returning to ON/OFF.
- blink_done is high for exactly the one cycle following the final frame_tick.
- Asynchronous reset mid-frame or mid-blink: outputs drop to reset values immediately. Operation resumes from OFF on the first edge after release.

## Test plan
- Pixel set: show=1, X0=208, Y0=100. Drive (209,100) with video_on=1 → rom_addr=0 after 1 cycle. rgb=12'hFFF and pixel_on=1 after 2 cycles (row 0 element 1 set).
- Pixel clear and out-of-bounds:
  - (208,100) → rgb=0 (element 0 clear).
  - (207,100) and (208,132) → rgb=0, rom_addr=0.
  - (431,131) → rom_addr=31 and rgb=12'hFFF.
- Blanking and hidden banner:
  - video_on=0 at (209,100) → rgb=0.
  - show=0 with any in-bounds pixel → rgb=0, pixel_on=0.
- Blink sequence (BLINK_FRAMES=2, BLINK_COUNT=2): win → busy=1.
  - Banner visible for ticks 1–2, dark for 3–4, visible for 5–6, dark for 7–8.
  - After tick 8: state ON, blink_done pulse of one cycle, busy=0.
  - A win at tick 3 changes nothing.
- Priority: show=0 coincident with win or during BLINK_OFF → OFF next edge, busy=0, no blink_done.
- Reset asserted mid-blink for 3 cycles → rgb/busy/rom_addr 0 asynchronously. After release with show=1 → ON on the first edge, not blinking.

Source files
------------

// File: rtl/banner_renderer.sv
// banner_renderer: two-stage pixel pipeline that overlays the 224x32
// "PLAYER 1" banner bitmap on the video stream, plus a frame-synchronous
// visibility FSM (OFF / ON / BLINK_ON / BLINK_OFF) driven by show/win.
//
// Ports:
//   clk         pixel clock, one pixel per cycle
//   reset       asynchronous, active-high
//   pixel_x/y   current coordinate from the sync generator (10 bits)
//   video_on    active-video flag aligned with pixel_x/pixel_y
//   frame_tick  one-cycle pulse per frame, during vertical blank
//   show        level, banner requested
//   win         one-cycle pulse, starts the blink sequence
//   rom_addr    registered row address to the combinational font ROM
//   rom_data    addressed ROM row, element 0 = leftmost pixel
//   rgb         registered pixel colour (2-cycle latency)
//   pixel_on    registered banner-pixel-lit flag (2-cycle latency)
//   busy        high while in either blink state
//   blink_done  one-cycle pulse when the blink sequence completes
module banner_renderer #(
  parameter int unsigned X0           = 208,
  parameter int unsigned Y0           = 100,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BLINK_COUNT  = 3,
  parameter logic [11:0] FG_COLOR     = 12'hFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   pixel_x,
  input  logic [9:0]   pixel_y,
  input  logic         video_on,
  input  logic         frame_tick,
  input  logic         show,
  input  logic         win,
  output logic [4:0]   rom_addr,
  input  logic [0:223] rom_data,
  output logic [11:0]  rgb,
  output logic         pixel_on,
  output logic         busy,
  output logic         blink_done
);

  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned CW = $clog2(BLINK_COUNT + 1);

  // 11-bit bounds so a banner near the right/bottom edge cannot wrap.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + 223);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + 31);

  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_ON,
    S_BLINK_ON,
    S_BLINK_OFF
  } state_t;

  state_t        state, state_d;
  logic [FW-1:0] frame_cnt, frame_d;
  logic [CW-1:0] pair_cnt, pair_d;
  logic          visible, busy_d, done_d;

  // ---------------- Stage 1: bounds test and address generation ----------
  logic [10:0] px_w, py_w;
  logic        hit_d;
  logic [7:0]  col_d;
  logic [4:0]  row_d;
  logic [7:0]  col_q;
  logic        hit_q, von_q;

  always_comb begin
    px_w  = {1'b0, pixel_x};
    py_w  = {1'b0, pixel_y};
    hit_d = video_on && (px_w >= X_LO) && (px_w <= X_HI)
                     && (py_w >= Y_LO) && (py_w <= Y_HI);
    col_d = 8'(px_w - X_LO);
    row_d = 5'(py_w - Y_LO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      rom_addr <= '0;
      hit_q    <= 1'b0;
      von_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      rom_addr <= hit_d ? row_d : '0;
      hit_q    <= hit_d;
      von_q    <= video_on;
    end
  end

  // ---------------- Stage 2: bit select and colour ------------------------
  logic pix_d;

  always_comb begin
    // Out-of-range col_q only occurs with hit_q=0, so the AND masks it.
    pix_d = hit_q && visible && rom_data[col_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on <= 1'b0;
      rgb      <= '0;
    end else begin
      pixel_on <= pix_d;
      rgb      <= (pix_d && von_q) ? FG_COLOR : '0;
    end
  end

  // ---------------- Visibility FSM: state register ------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OFF;
      frame_cnt  <= '0;
      pair_cnt   <= '0;
      busy       <= 1'b0;
      blink_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_cnt  <= frame_d;
      pair_cnt   <= pair_d;
      busy       <= busy_d;
      blink_done <= done_d;
    end
  end

  // ---------------- Visibility FSM: next state ----------------------------
  always_comb begin
    state_d = state;
    frame_d = frame_cnt;
    pair_d  = pair_cnt;
    if (!show) begin
      state_d = S_OFF;
      frame_d = '0;
      pair_d  = '0;
    end else begin
      unique case (state)
        S_OFF: state_d = S_ON;
        S_ON: begin
          // A frame_tick coincident with win is not counted.
          if (win) begin
            state_d = S_BLINK_ON;
            frame_d = '0;
            pair_d  = '0;
          end
        end
        S_BLINK_ON: begin
          if (frame_tick) begin
            if (frame_cnt == F_LAST) begin
              state_d = S_BLINK_OFF;
              frame_d = '0;
            end else begin
              frame_d = frame_cnt + FW'(1);
            end
          end
        end
        S_BLINK_OFF: begin
          if (frame_tick) begin
            if (frame_cnt == F_LAST) begin
              frame_d = '0;
              if (pair_cnt == P_LAST) begin
                state_d = S_ON;
                pair_d  = '0;
              end else begin
                state_d = S_BLINK_ON;
                pair_d  = pair_cnt + CW'(1);
              end
            end else begin
              frame_d = frame_cnt + FW'(1);
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // ---------------- Visibility FSM: outputs -------------------------------
  always_comb begin
    visible = (state == S_ON) || (state == S_BLINK_ON);
    // busy/blink_done are registered from the next state so they line up
    // with the state register itself.
    busy_d  = (state_d == S_BLINK_ON) || (state_d == S_BLINK_OFF);
    done_d  = (state == S_BLINK_OFF) && (state_d == S_ON);
  end

endmodule

// File: tb/tb_banner_renderer.sv
// Directed, table-driven bench for banner_renderer with a behavioural font
// ROM: element c of row r is set when (c%3==1) XOR (r%4==2).
module tb_banner_renderer;

  logic         clk;
  logic         reset;
  logic [9:0]   pixel_x, pixel_y;
  logic         video_on, frame_tick, show, win;
  logic [4:0]   rom_addr;
  logic [0:223] rom_data;
  logic [11:0]  rgb;
  logic         pixel_on, busy, blink_done;

  int n_checks = 0;
  int n_fail   = 0;

  banner_renderer #(
    .X0(208), .Y0(100), .BLINK_FRAMES(2), .BLINK_COUNT(2), .FG_COLOR(12'hFFF)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .show(show), .win(win),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb),
    .pixel_on(pixel_on), .busy(busy), .blink_done(blink_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:223] rom_row(input logic [4:0] r);
    logic [0:223] v;
    for (int c = 0; c < 224; c++) v[c] = ((c % 3) == 1) ^ ((int'(r) % 4) == 2);
    return v;
  endfunction

  assign rom_data = rom_row(rom_addr);

  typedef struct {
    logic [9:0]  x, y;
    logic        von, shw;
    logic [4:0]  addr;
    logic [11:0] col;
    logic        on;
  } vec_t;

  function automatic vec_t mk(input int x, input int y, input bit von, input bit shw,
                              input int addr, input int col, input bit on);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.von = von; v.shw = shw;
    v.addr = 5'(addr); v.col = 12'(col); v.on = on;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick(input logic w);
    frame_tick = 1'b1;
    win        = w;
    step();
    frame_tick = 1'b0;
    win        = 1'b0;
  endtask

  vec_t vecs[13];
  logic vis_exp[1:8];

  initial begin
    vecs[0]  = mk(209, 100, 1, 1,  0, 12'hFFF, 1);
    vecs[1]  = mk(208, 100, 1, 1,  0, 12'h000, 0);
    vecs[2]  = mk(207, 100, 1, 1,  0, 12'h000, 0);
    vecs[3]  = mk(208, 132, 1, 1,  0, 12'h000, 0);
    vecs[4]  = mk(431, 131, 1, 1, 31, 12'hFFF, 1);
    vecs[5]  = mk(209, 100, 0, 1,  0, 12'h000, 0);
    vecs[6]  = mk(209, 100, 1, 0,  0, 12'h000, 0);
    vecs[7]  = mk(210, 102, 1, 1,  2, 12'hFFF, 1);
    vecs[8]  = mk(209, 102, 1, 1,  2, 12'h000, 0);
    vecs[9]  = mk(432, 131, 1, 1,  0, 12'h000, 0);
    vecs[10] = mk(300, 115, 1, 1, 15, 12'h000, 0);
    vecs[11] = mk(302, 115, 1, 1, 15, 12'hFFF, 1);
    vecs[12] = mk(431,  99, 1, 1,  0, 12'h000, 0);
    vis_exp[1] = 1; vis_exp[2] = 0; vis_exp[3] = 0; vis_exp[4] = 1;
    vis_exp[5] = 1; vis_exp[6] = 0; vis_exp[7] = 0; vis_exp[8] = 1;

    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    frame_tick = 1'b0; show = 1'b0; win = 1'b0;
    step();
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_pixel_on", 32'(pixel_on), 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_blink_done", 32'(blink_done), 0);
    reset = 1'b0;

    // Pixel table: coordinate held for two edges.
    for (int i = 0; i < 13; i++) begin
      pixel_x = vecs[i].x; pixel_y = vecs[i].y;
      video_on = vecs[i].von; show = vecs[i].shw;
      step();
      chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      step();
      chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].col));
      chk($sformatf("vec%0d_pixel_on", i), 32'(pixel_on), 32'(vecs[i].on));
    end

    // Blink sequence from ON; win arrives together with a tick that must not count.
    pixel_x = 10'd209; pixel_y = 10'd100; video_on = 1'b1; show = 1'b1;
    step();
    pulse_tick(1'b1);
    chk("blink_start_busy", 32'(busy), 1);
    chk("blink_start_done", 32'(blink_done), 0);
    step();
    chk("blink_start_vis", 32'(pixel_on), 1);
    for (int k = 1; k <= 8; k++) begin
      pulse_tick(k == 3);
      chk($sformatf("tick%0d_busy", k), 32'(busy), (k < 8) ? 1 : 0);
      chk($sformatf("tick%0d_done", k), 32'(blink_done), (k == 8) ? 1 : 0);
      step();
      chk($sformatf("tick%0d_vis", k), 32'(pixel_on), 32'(vis_exp[k]));
      chk($sformatf("tick%0d_done_gone", k), 32'(blink_done), 0);
    end

    // show=0 beats win.
    win = 1'b1; show = 1'b0;
    step();
    win = 1'b0;
    chk("prio_win_busy", 32'(busy), 0);
    chk("prio_win_done", 32'(blink_done), 0);
    step();
    chk("prio_win_vis", 32'(pixel_on), 0);

    // show=0 on the final BLINK_OFF tick: no blink_done.
    show = 1'b1;
    step();
    win = 1'b1;
    step();
    win = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      pulse_tick(1'b0);
      step();
    end
    chk("prio_off_busy_before", 32'(busy), 1);
    chk("prio_off_vis_before", 32'(pixel_on), 0);
    show = 1'b0;
    pulse_tick(1'b0);
    chk("prio_off_busy", 32'(busy), 0);
    chk("prio_off_done", 32'(blink_done), 0);
    step();
    chk("prio_off_done_later", 32'(blink_done), 0);

    // Asynchronous reset in the middle of BLINK_ON.
    pixel_x = 10'd431; pixel_y = 10'd131; show = 1'b1;
    step();
    win = 1'b1;
    step();
    win = 1'b0;
    step();
    chk("prerst_rgb", 32'(rgb), 32'h0FFF);
    chk("prerst_rom_addr", 32'(rom_addr), 31);
    chk("prerst_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rgb", 32'(rgb), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_rom_addr", 32'(rom_addr), 0);
    chk("async_rst_pixel_on", 32'(pixel_on), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rom_addr", 32'(rom_addr), 31);
    step();
    chk("post_rst_rgb", 32'(rgb), 32'h0FFF);
    pulse_tick(1'b0);
    chk("post_rst_tick_busy", 32'(busy), 0);
    step();
    chk("post_rst_tick_vis", 32'(pixel_on), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
